// File: rtl/enemy_array_hit.sv
// rtl/enemy_array_hit.sv - multi-enemy projectile hit detector with HP, flash window, score and wave-clear
module enemy_array_hit #(
  parameter int NUM_ENEMIES  = 4,
  parameter int HIT_RADIUS   = 25,
  parameter int MAX_HP       = 2,
  parameter int FLASH_CYCLES = 4,
  parameter int POINTS_HIT   = 1,
  parameter int POINTS_KILL  = 5,
  parameter int SCORE_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_ENEMIES*10-1:0] enemy_h,
  input  logic [NUM_ENEMIES*10-1:0] enemy_v,
  input  logic [9:0]                proj_h,
  input  logic [9:0]                proj_v,
  input  logic                      proj_valid,
  output logic                      proj_consume,
  output logic [NUM_ENEMIES-1:0]    hit_pulse,
  output logic [NUM_ENEMIES-1:0]    alive,
  output logic [NUM_ENEMIES-1:0]    flashing,
  output logic [SCORE_W-1:0]        score,
  output logic                      wave_clear
);

  localparam int N     = NUM_ENEMIES;
  localparam int HP_W  = $clog2(MAX_HP + 1);
  localparam int CNT_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

  localparam logic signed [10:0]   RADIUS    = 11'(HIT_RADIUS);
  localparam logic [HP_W-1:0]      HP_FULL   = HP_W'(MAX_HP);
  localparam logic [HP_W-1:0]      HP_ONE    = HP_W'(1);
  localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [SCORE_W:0]     ADD_HIT   = (SCORE_W + 1)'(POINTS_HIT);
  localparam logic [SCORE_W:0]     ADD_KILL  = (SCORE_W + 1)'(POINTS_KILL);

  typedef enum logic [1:0] {
    ST_DEAD  = 2'd0,
    ST_ALIVE = 2'd1,
    ST_FLASH = 2'd2
  } state_t;

  state_t           state_q [N];
  state_t           state_d [N];
  logic [HP_W-1:0]  hp_q    [N];
  logic [HP_W-1:0]  hp_d    [N];
  logic [CNT_W-1:0] cnt_q   [N];
  logic [CNT_W-1:0] cnt_d   [N];

  logic [N-1:0]     cand;
  logic [N-1:0]     win;
  logic             any_hit;
  logic             any_fatal;
  logic             any_alive_d;
  logic             wave_active;
  logic [SCORE_W:0] score_add;
  logic [SCORE_W:0] score_sum;
  logic [SCORE_W-1:0] score_d;

  // Signed 11-bit difference keeps enemies near the screen edge hittable from the low side.
  function automatic logic in_box(input logic [9:0] p, input logic [9:0] e);
    logic signed [10:0] d;
    d = $signed({1'b0, p}) - $signed({1'b0, e});
    return (d >= -RADIUS) && (d <= RADIUS);
  endfunction

  // Candidate enemies: live, not flashing, and inside the square hit box.
  always_comb begin
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand[i] = proj_valid && (state_q[i] == ST_ALIVE)
                && in_box(proj_h, enemy_h[i*10 +: 10])
                && in_box(proj_v, enemy_v[i*10 +: 10]);
    end
  end

  // Lowest-index candidate takes the projectile; the rest are untouched.
  always_comb begin
    logic taken;
    win   = '0;
    taken = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cand[i] && !taken) begin
        win[i] = 1'b1;
        taken  = 1'b1;
      end
    end
  end

  // Per-enemy next state: flash countdown and hit handling.
  always_comb begin
    any_fatal   = 1'b0;
    any_alive_d = 1'b0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      hp_d[i]    = hp_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_FLASH: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = ST_ALIVE;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        ST_ALIVE: begin
          if (win[i]) begin
            if (hp_q[i] == HP_ONE) begin
              state_d[i] = ST_DEAD;
              hp_d[i]    = '0;
              any_fatal  = 1'b1;
            end else begin
              state_d[i] = ST_FLASH;
              hp_d[i]    = hp_q[i] - 1'b1;
              cnt_d[i]   = CNT_LOAD;
            end
          end
        end
        default: begin
          state_d[i] = ST_DEAD;
        end
      endcase
      if (state_d[i] != ST_DEAD) begin
        any_alive_d = 1'b1;
      end
    end
  end

  // Saturating score accumulation.
  always_comb begin
    any_hit   = |win;
    score_add = '0;
    if (any_fatal) begin
      score_add = ADD_KILL;
    end else if (any_hit) begin
      score_add = ADD_HIT;
    end
    score_sum = {1'b0, score} + score_add;
    score_d   = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  // Status views derived from the registered per-enemy state.
  always_comb begin
    alive    = '0;
    flashing = '0;
    for (int i = 0; i < N; i++) begin
      alive[i]    = (state_q[i] != ST_DEAD);
      flashing[i] = (state_q[i] == ST_FLASH);
    end
  end

  // State registers: reset, then wave start, then normal hit processing.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_DEAD;
        hp_q[i]    <= '0;
        cnt_q[i]   <= '0;
      end
      hit_pulse    <= '0;
      proj_consume <= 1'b0;
      score        <= '0;
      wave_clear   <= 1'b0;
      wave_active  <= 1'b0;
    end else if (start) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_ALIVE;
        hp_q[i]    <= HP_FULL;
        cnt_q[i]   <= '0;
      end
      hit_pulse    <= '0;
      proj_consume <= 1'b0;
      score        <= '0;
      wave_clear   <= 1'b0;
      wave_active  <= 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        hp_q[i]    <= hp_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      hit_pulse    <= win;
      proj_consume <= any_hit;
      score        <= score_d;
      if (wave_active && !any_alive_d) begin
        wave_clear  <= 1'b1;
        wave_active <= 1'b0;
      end else begin
        wave_clear  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_enemy_array_hit.sv
// tb/tb_enemy_array_hit.sv - scoreboard testbench for enemy_array_hit
module tb_enemy_array_hit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [39:0] enemy_h;
  logic [39:0] enemy_v;
  logic [9:0]  proj_h;
  logic [9:0]  proj_v;
  logic        proj_valid;
  logic        proj_consume;
  logic [3:0]  hit_pulse;
  logic [3:0]  alive;
  logic [3:0]  flashing;
  logic [15:0] score;
  logic        wave_clear;

  typedef struct packed {
    logic [3:0]  hp;
    logic [15:0] sc;
  } hit_exp_t;

  hit_exp_t    hit_q[$];
  logic [15:0] wave_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;

  enemy_array_hit dut (
    .clk(clk), .reset(reset), .start(start),
    .enemy_h(enemy_h), .enemy_v(enemy_v),
    .proj_h(proj_h), .proj_v(proj_v), .proj_valid(proj_valid),
    .proj_consume(proj_consume), .hit_pulse(hit_pulse),
    .alive(alive), .flashing(flashing), .score(score), .wave_clear(wave_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops expected events when the DUT reports a consume or wave clear.
  always @(negedge clk) begin
    if (mon_en) begin
      if (proj_consume === 1'b1) begin
        if (hit_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_consume: hit_pulse=%b score=%0d", hit_pulse, score);
        end else begin
          hit_exp_t e;
          e = hit_q.pop_front();
          checks += 2;
          if (hit_pulse !== e.hp) begin
            errors++;
            $display("FAIL hit_pulse: got %b expected %b", hit_pulse, e.hp);
          end
          if (score !== e.sc) begin
            errors++;
            $display("FAIL hit_score: got %0d expected %0d", score, e.sc);
          end
        end
      end else if (hit_pulse !== 4'b0000) begin
        checks++; errors++;
        $display("FAIL stray_hit_pulse: got %b expected 0000", hit_pulse);
      end
      if (wave_clear === 1'b1) begin
        checks++;
        if (wave_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wave_clear: score=%0d", score);
        end else begin
          logic [15:0] ws;
          ws = wave_q.pop_front();
          if (score !== ws) begin
            errors++;
            $display("FAIL wave_clear_score: got %0d expected %0d", score, ws);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [9:0] ph, input logic [9:0] pv, input logic v);
    proj_h = ph; proj_v = pv; proj_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(10'd0, 10'd0, 1'b0);
  endtask

  task automatic hit(input logic [9:0] ph, input logic [9:0] pv,
                     input logic [3:0] hp, input logic [15:0] sc);
    hit_q.push_back('{hp: hp, sc: sc});
    cyc(ph, pv, 1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; proj_valid = 1'b0; proj_h = '0; proj_v = '0;
    // slot0 (100,100), slot1 (300,200), slot2 (300,200), slot3 (10,5)
    enemy_h = {10'd10, 10'd300, 10'd300, 10'd100};
    enemy_v = {10'd5,  10'd200, 10'd200, 10'd100};
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    chk("reset_alive", 32'(alive), 32'h0);
    chk("reset_score", 32'(score), 32'h0);
    chk("reset_flash", 32'(flashing), 32'h0);
    cyc(10'd100, 10'd100, 1'b1);
    reset = 1'b0;

    start = 1'b1; cyc(10'd0, 10'd0, 1'b0); start = 1'b0;
    chk("start_alive", 32'(alive), 32'hF);
    chk("start_score", 32'(score), 32'h0);

    // Just outside the box on x: no hit.
    cyc(10'd126, 10'd100, 1'b1);
    chk("miss_score", 32'(score), 32'h0);

    // Corner of the box: non-fatal hit on enemy0.
    hit(10'd125, 10'd75, 4'b0001, 16'd1);
    chk("hit0_flash", 32'(flashing), 32'h1);
    for (int k = 0; k < 4; k++) cyc(10'd125, 10'd75, 1'b1);
    chk("flash0_end", 32'(flashing), 32'h0);
    hit(10'd125, 10'd75, 4'b0001, 16'd6);
    chk("kill0_alive", 32'(alive), 32'hE);

    // Overlapping enemies 1 and 2: lowest index wins.
    hit(10'd300, 10'd200, 4'b0010, 16'd7);
    chk("overlap_flash", 32'(flashing), 32'h2);
    idle(4);
    hit(10'd300, 10'd200, 4'b0010, 16'd12);
    hit(10'd300, 10'd200, 4'b0100, 16'd13);
    chk("e2_first_nonfatal", 32'(alive), 32'hC);
    idle(4);
    hit(10'd300, 10'd200, 4'b0100, 16'd18);

    // Enemy near the origin hit from below the screen edge.
    hit(10'd0, 10'd0, 4'b1000, 16'd19);
    idle(4);
    wave_q.push_back(16'd24);
    hit(10'd0, 10'd0, 4'b1000, 16'd24);
    chk("final_alive", 32'(alive), 32'h0);
    chk("final_wave_clear", 32'(wave_clear), 32'h1);
    idle(3);

    // Start together with a valid projectile: no consume.
    start = 1'b1; cyc(10'd100, 10'd100, 1'b1); start = 1'b0;
    chk("restart_alive", 32'(alive), 32'hF);
    chk("restart_score", 32'(score), 32'h0);
    chk("restart_consume", 32'(proj_consume), 32'h0);

    // Mid-wave reset.
    hit(10'd100, 10'd100, 4'b0001, 16'd1);
    reset = 1'b1; cyc(10'd0, 10'd0, 1'b0); reset = 1'b0;
    chk("midreset_alive", 32'(alive), 32'h0);
    chk("midreset_score", 32'(score), 32'h0);
    chk("midreset_flash", 32'(flashing), 32'h0);
    for (int k = 0; k < 3; k++) cyc(10'd100, 10'd100, 1'b1);
    proj_valid = 1'b0;
    idle(2);

    chk("hit_queue_drained", 32'(hit_q.size()), 32'h0);
    chk("wave_queue_drained", 32'(wave_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
